// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the LEGv8 datapath.
// The controller owns the master view: it consumes instr/mem_ready and drives every enable and select.
interface multicycle_controller_if;
    logic [10:0] instr;
    logic        mem_ready;
    logic        IorD;
    logic        memRead;
    logic        memWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCSource;
    logic        reg2loc;
    logic        regWrite;
    logic        memtoReg;
    logic        AluSrcA;
    logic [1:0]  AluSrcB;
    logic [3:0]  AluControl;
    logic        instr_done;
    logic        illegal;

    modport master (
        input  instr, mem_ready,
        output IorD, memRead, memWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
               reg2loc, regWrite, memtoReg, AluSrcA, AluSrcB, AluControl,
               instr_done, illegal
    );

    modport slave (
        output instr, mem_ready,
        input  IorD, memRead, memWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
               reg2loc, regWrite, memtoReg, AluSrcA, AluSrcB, AluControl,
               instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 sequencer: Moore FSM with registered per-state enables.
// Handshake: a memory access requested by memRead/memWrite completes in the cycle mem_ready is high.
module multicycle_controller #(
    parameter int ST_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus,
    output logic [ST_W-1:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_CBZ    = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    // Registered view of the current state's outputs; fetch/decode/wr_wait
    // mark the few outputs that are further qualified by mem_ready or instr.
    typedef struct packed {
        logic       fetch;
        logic       decode;
        logic       wr_wait;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       reg2loc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       done;
    } ctrl_t;

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_q;
    logic       active_q;
    logic       is_ldur;
    logic       is_stur;
    logic       is_rtype;
    logic       is_cbz;
    logic       is_b;
    logic       is_legal;
    logic [3:0] exec_alu;

    assign is_ldur  = (bus.instr == OP_LDUR);
    assign is_stur  = (bus.instr == OP_STUR);
    assign is_rtype = (bus.instr == OP_ADD) || (bus.instr == OP_SUB) ||
                      (bus.instr == OP_AND) || (bus.instr == OP_ORR);
    assign is_cbz   = (bus.instr[10:3] == 8'b10110100);
    assign is_b     = (bus.instr[10:5] == 6'b000101);
    assign is_legal = is_ldur || is_stur || is_rtype || is_cbz || is_b;

    always_comb begin
        exec_alu = ALU_ADD;
        case (bus.instr)
            OP_SUB:  exec_alu = ALU_SUB;
            OP_AND:  exec_alu = ALU_AND;
            OP_ORR:  exec_alu = ALU_ORR;
            default: exec_alu = ALU_ADD;
        endcase
    end

    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] alu_exec);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.decode    = 1'b1;
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.reg2loc   = 1'b1;
                c.wr_wait   = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_exec;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_CBZ: begin
                c.reg2loc       = 1'b1;
                c.alu_src_a     = 1'b1;
                c.alu_control   = ALU_PASS;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
                c.done          = 1'b1;
            end
            S_BRANCH: begin
                c.pc_write  = 1'b1;
                c.pc_source = 1'b1;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // The edge that releases reset only arms the machine; FETCH starts on it.
    always_comb begin
        state_d = S_FETCH;
        if (active_q) begin
            case (state_q)
                S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (is_ldur || is_stur) state_d = S_MEMADR;
                    else if (is_rtype)      state_d = S_EXEC;
                    else if (is_cbz)        state_d = S_CBZ;
                    else if (is_b)          state_d = S_BRANCH;
                    else                    state_d = S_FETCH;
                end
                S_MEMADR: state_d = is_ldur ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_d = S_FETCH;
                S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   state_d = S_ALUWB;
                S_ALUWB:  state_d = S_FETCH;
                S_CBZ:    state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            active_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            ctrl_q   <= ctrl_for(state_d, exec_alu);
        end
    end

    assign bus.IorD        = ctrl_q.iord;
    assign bus.memRead     = ctrl_q.mem_read;
    assign bus.memWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.fetch & bus.mem_ready;
    assign bus.PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.reg2loc     = ctrl_q.reg2loc | (ctrl_q.decode & (is_stur | is_cbz));
    assign bus.regWrite    = ctrl_q.reg_write;
    assign bus.memtoReg    = ctrl_q.mem_to_reg;
    assign bus.AluSrcA     = ctrl_q.alu_src_a;
    assign bus.AluSrcB     = ctrl_q.alu_src_b;
    assign bus.AluControl  = ctrl_q.alu_control;
    assign bus.instr_done  = ctrl_q.done | (ctrl_q.wr_wait & bus.mem_ready);
    assign bus.illegal     = ctrl_q.decode & ~is_legal;
    assign state           = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle trace against a phase-level reference model.
// Each exp_q entry packs {state[3:0], mem_ready to drive, expected outputs[18:0]}.
module tb_multicycle_controller;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] state;
  logic [18:0] obs;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [10:0] ins_q[$];

  multicycle_controller_if bus();

  multicycle_controller #(.ST_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {bus.IorD, bus.memRead, bus.memWrite, bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.PCSource, bus.reg2loc, bus.regWrite, bus.memtoReg,
                bus.AluSrcA, bus.AluSrcB, bus.AluControl, bus.instr_done, bus.illegal};

  // 0 LDUR, 1 STUR, 2 R-type, 3 CBZ, 4 B, 5 unsupported
  function automatic int op_class(input logic [10:0] op);
    logic [7:0] hi8;
    logic [5:0] hi6;
    hi8 = op[10:3];
    hi6 = op[10:5];
    if (op == 11'h7C2) return 0;
    if (op == 11'h7C0) return 1;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return 2;
    if (hi8 == 8'hB4) return 3;
    if (hi6 == 6'h05) return 4;
    return 5;
  endfunction

  function automatic logic [18:0] exp_outs(input int st, input logic mr, input logic [10:0] op);
    logic iord, mrd, mwr, irw, pcw, pcc, pcs, r2l, rw, m2r, asa, done, ill;
    logic [1:0] asb;
    logic [3:0] alu;
    int cls;
    cls = op_class(op);
    {iord, mrd, mwr, irw, pcw, pcc, pcs, r2l, rw, m2r, asa, done, ill} = '0;
    asb = 2'b00;
    alu = 4'b0010;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1: begin asb = 2'b11; r2l = (cls == 1 || cls == 3); ill = (cls == 5); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; done = 1; end
      5: begin mwr = 1; iord = 1; r2l = 1; done = mr; end
      6: begin
        asa = 1;
        case (op)
          11'h658: alu = 4'b0110;
          11'h450: alu = 4'b0000;
          11'h550: alu = 4'b0001;
          default: alu = 4'b0010;
        endcase
      end
      7: begin rw = 1; done = 1; end
      8: begin r2l = 1; asa = 1; alu = 4'b0111; pcc = 1; pcs = 1; done = 1; end
      9: begin pcw = 1; pcs = 1; done = 1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, pcw, pcc, pcs, r2l, rw, m2r, asa, asb, alu, done, ill};
  endfunction

  task automatic push(input int st, input logic mr, input logic [10:0] op);
    logic [3:0] s4;
    s4 = 4'(st);
    exp_q.push_back({s4, mr, exp_outs(st, mr, op)});
    ins_q.push_back(op);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Phase list per instruction class, with the requested number of wait cycles.
  task automatic add_instr(input logic [10:0] op, input int fw, input int mw);
    int cls;
    cls = op_class(op);
    for (int i = 0; i < fw; i++) push(0, 1'b0, op);
    push(0, 1'b1, op);
    push(1, rnd_bit(), op);
    case (cls)
      0: begin
        push(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) push(3, 1'b0, op);
        push(3, 1'b1, op);
        push(4, rnd_bit(), op);
      end
      1: begin
        push(2, rnd_bit(), op);
        for (int i = 0; i < mw; i++) push(5, 1'b0, op);
        push(5, 1'b1, op);
      end
      2: begin push(6, rnd_bit(), op); push(7, rnd_bit(), op); end
      3: push(8, rnd_bit(), op);
      4: push(9, rnd_bit(), op);
      default: ;
    endcase
  endtask

  task automatic drain(input string name);
    logic [W-1:0] e;
    logic [10:0] op;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      op = ins_q.pop_front();
      @(posedge clk);
      #1;
      bus.mem_ready = e[19];
      if (e[23:20] == 4'd1) bus.instr = op;
      @(negedge clk);
      checks++;
      if (state !== e[23:20]) begin
        failures++;
        $display("FAIL %s cyc%0d state: got=%0d exp=%0d", name, cyc, state, e[23:20]);
      end
      checks++;
      if (obs !== e[18:0]) begin
        failures++;
        $display("FAIL %s cyc%0d outputs (state %0d op %h): got=%b exp=%b", name, cyc, e[23:20], op, obs, e[18:0]);
      end
      checks++;
      if ((bus.memRead & bus.memWrite) || (bus.regWrite & (bus.PCWrite | bus.PCWriteCond))) begin
        failures++;
        $display("FAIL %s cyc%0d exclusivity: got=%b exp=no overlap", name, cyc, obs);
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.instr = 11'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ready = rnd_bit();
      #1;
      checks++;
      if (state !== 4'd0 || obs !== 19'd0) begin
        failures++;
        $display("FAIL reset_hold state/outputs: got=%0d/%b exp=0/0", state, obs);
      end
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    add_instr(11'h458, 0, 0);
    drain("reset_release");
  endtask

  task automatic test_rtype();
    logic [10:0] ops[4];
    ops = '{11'h458, 11'h658, 11'h450, 11'h550};
    for (int i = 0; i < 4; i++) add_instr(ops[i], 0, 0);
    drain("rtype");
    for (int i = 0; i < 4; i++) add_instr(ops[i], $urandom_range(0, 2), 0);
    drain("rtype_wait");
  endtask

  task automatic test_ldur();
    add_instr(11'h7C2, 0, 2);
    drain("ldur_wait2");
    add_instr(11'h7C2, $urandom_range(1, 3), 0);
    drain("ldur_fetchwait");
  endtask

  task automatic test_stur();
    add_instr(11'h7C0, 0, 0);
    drain("stur");
    add_instr(11'h7C0, 1, $urandom_range(1, 3));
    drain("stur_wait");
  endtask

  task automatic test_branch();
    add_instr(11'h5A0, 0, 0);
    add_instr(11'h0A0, 0, 0);
    drain("cbz_b");
  endtask

  task automatic test_illegal();
    add_instr(11'h000, 0, 0);
    add_instr(11'h458, 0, 0);
    drain("illegal");
  endtask

  task automatic test_random();
    logic [10:0] legal[8];
    logic [10:0] op;
    legal = '{11'h7C2, 11'h7C0, 11'h458, 11'h658, 11'h450, 11'h550, 11'h5A0, 11'h0A0};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 11'($urandom_range(0, 2047));
      else op = legal[$urandom_range(0, 7)];
      if (op_class(op) == 3) op[2:0] = 3'($urandom_range(0, 7));
      if (op_class(op) == 4) op[4:0] = 5'($urandom_range(0, 31));
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    drain("random");
  endtask

  task automatic test_reset_midwait();
    push(0, 1'b1, 11'h7C0);
    push(1, 1'b1, 11'h7C0);
    push(2, 1'b1, 11'h7C0);
    push(5, 1'b0, 11'h7C0);
    push(5, 1'b0, 11'h7C0);
    drain("reset_midwait_pre");
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.memWrite !== 1'b0 || state !== 4'd0 || obs !== 19'd0) begin
      failures++;
      $display("FAIL reset_midwait async drop: got=%0d/%b exp=0/0", state, obs);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    add_instr(11'h7C0, 0, 0);
    drain("reset_midwait_post");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldur();
    test_stur();
    test_branch();
    test_illegal();
    test_random();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the LEGv8 subset (LDUR, STUR, CBZ, B, ADD, SUB, AND, ORR). It replaces the single-cycle main/ALU decoder pair when the datapath is split into fetch/decode/execute/memory/writeback steps over a shared ALU and a unified instruction/data memory. A Moore FSM drives the datapath enables and mux selects. A mem_ready handshake stalls the FSM on every memory access.

Parameters:
ST_W, 4, width of state encoding and debug port

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
instr  in  11  instruction [31:21] from IR; stable from DECODE until next FETCH
mem_ready  in  1  memory completes current access this cycle
IorD  out  1  0=PC addresses memory, 1=ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if datapath zero flag
PCSource  out  1  0=ALU result, 1=ALUOut
reg2loc  out  1  1=read register 2 from Rt [4:0]
regWrite  out  1  register file write
memtoReg  out  1  1=write-back from MDR
AluSrcA  out  1  0=PC, 1=reg A
AluSrcB  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
AluControl  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B
instr_done  out  1  one-cycle pulse on final cycle of each instruction
illegal  out  1  one-cycle pulse on unsupported opcode
state  out  ST_W  current state (debug)

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, CBZ 8, BRANCH 9. Codes 10-15 are unreachable; if entered, return to FETCH next cycle with all enables 0.
- Reset (asynchronous): state=FETCH. While reset is high, every output is 0. First FETCH cycle is the first clk edge after reset release.
- Default for every output not listed in a state: 0. AluControl defaults to 0010.
- FETCH: memRead=1, IorD=0, AluSrcA=0, AluSrcB=01, ADD, PCSource=0.
  - mem_ready=1: IRWrite=1, PCWrite=1, then DECODE.
  - mem_ready=0: IRWrite=PCWrite=0, stay in FETCH.
- DECODE: AluSrcA=0, AluSrcB=11, ADD (branch target into ALUOut). reg2loc=1 for STUR/CBZ. Next state by opcode:
  - LDUR 11111000010 or STUR 11111000000 -> MEMADR
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC
  - CBZ instr[10:3]=10110100 -> CBZ
  - B instr[10:5]=000101 -> BRANCH
  - anything else: illegal=1, then FETCH (treated as NOP, no instr_done)
- MEMADR: AluSrcA=1, AluSrcB=10, ADD. Next MEMRD if LDUR, else MEMWR.
- MEMRD: memRead=1, IorD=1. Stay until mem_ready, then MEMWB.
- MEMWB: regWrite=1, memtoReg=1, instr_done=1, then FETCH.
- MEMWR: memWrite=1, IorD=1, reg2loc=1. Stay until mem_ready; on the mem_ready cycle instr_done=1, then FETCH.
- EXEC: AluSrcA=1, AluSrcB=00, AluControl from opcode (ADD 0010, SUB 0110, AND 0000, ORR 0001). Next ALUWB.
- ALUWB: regWrite=1, memtoReg=0, instr_done=1, then FETCH.
- CBZ: reg2loc=1, AluSrcA=1, AluSrcB=00, AluControl=0111, PCWriteCond=1, PCSource=1, instr_done=1, then FETCH.
- BRANCH: PCWrite=1, PCSource=1, instr_done=1, then FETCH.
- Cycle counts with zero wait: LDUR 5, STUR 4, R-type 4, CBZ 3, B 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- memRead and memWrite are never high together. regWrite is never high in the same cycle as PCWrite or PCWriteCond.
- Reset asserted mid-instruction (including during a memory wait): all outputs drop to 0 immediately; the FSM restarts at FETCH.

Test Plan:
- Reset held, then released with mem_ready=1 -> all outputs 0 during reset; first edge after release shows state=0 with memRead=1, IRWrite=1, PCWrite=1, AluSrcB=01.
- ADD (11'h458), mem_ready=1 -> state sequence 0,1,6,7; EXEC AluControl=0010; ALUWB regWrite=1 and instr_done=1. Repeat with SUB (11'h658) -> 0110, AND (11'h450) -> 0000, ORR (11'h550) -> 0001.
- LDUR (11'h7C2) with mem_ready low 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0 (7 cycles); MEMWB regWrite=1, memtoReg=1.
- STUR (11'h7C0), mem_ready=1 -> sequence 0,1,2,5,0; MEMWR memWrite=1, IorD=1, reg2loc=1, instr_done=1; regWrite stays 0 throughout.
- CBZ (11'h5A0) then B (11'h0A0) -> CBZ: 3 cycles with PCWriteCond=1, AluControl=0111; B: 3 cycles with PCWrite=1, PCSource=1 in state 9.
- Opcode 11'h000 -> illegal pulses in DECODE, next state FETCH, no instr_done. Separately, assert reset during a MEMWR wait -> memWrite falls asynchronously and state=0.
